// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the fetch-address generator.
//   redir_class_e : redirect source, encoded so a numeric compare is priority.
//   redir_req_t   : one arbitrated redirect (class + target).
//   pc_state_e    : IDLE / PEND state of the stall-latch FSM.
package pc_pkg;

  typedef enum logic [1:0] {
    RC_NONE = 2'd0,
    RC_ID   = 2'd1,
    RC_EX   = 2'd2,
    RC_TRAP = 2'd3
  } redir_class_e;

  typedef struct packed {
    redir_class_e cls;
    logic [31:0]  target;
  } redir_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/pc_redir_arb.sv
// pc_redir_arb: ISSUE_W-slot redirect selector, lowest (oldest) slot wins.
//   i_valid : per-slot request valid
//   i_pc    : per-slot target, slot i in [32*i +: 32]
//   o_req   : {CLS, target} of the winning slot, or RC_NONE when idle
module pc_redir_arb
  import pc_pkg::*;
#(
  parameter int           ISSUE_W = 2,
  parameter redir_class_e CLS     = RC_EX
) (
  input  logic [ISSUE_W-1:0]    i_valid,
  input  logic [32*ISSUE_W-1:0] i_pc,
  output redir_req_t            o_req
);

  // Scan from the youngest slot down so the oldest valid slot is written last.
  always_comb begin
    o_req = '{cls: RC_NONE, target: '0};
    for (int i = ISSUE_W - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_req.cls    = CLS;
        o_req.target = i_pc[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with prioritised redirects and a stall latch.
//   clk, rst          : clock, synchronous active-high reset
//   stallF            : hold pc this cycle
//   trap_valid/pc     : M-stage exception / ERET redirect (highest priority)
//   ex_redir_valid/pc : E-stage mispredict, per slot
//   id_redir_valid/pc : D-stage jump / predicted-taken, per slot
//   pc                : current fetch address
//   redirect_pending  : a redirect is held waiting for the stall to drop
//   redirect_taken    : pc was loaded from a redirect on the last edge
module pc_gen
  import pc_pkg::*;
#(
  parameter int          ISSUE_W     = 2,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          FETCH_BYTES = 4 * ISSUE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallF,
  input  logic                  trap_valid,
  input  logic [31:0]           trap_pc,
  input  logic [ISSUE_W-1:0]    ex_redir_valid,
  input  logic [32*ISSUE_W-1:0] ex_redir_pc,
  input  logic [ISSUE_W-1:0]    id_redir_valid,
  input  logic [32*ISSUE_W-1:0] id_redir_pc,
  output logic [31:0]           pc,
  output logic                  redirect_pending,
  output logic                  redirect_taken
);

  pc_state_e   r_state, w_state_nxt;
  redir_req_t  r_pend,  w_pend_nxt;
  logic [31:0] r_pc,    w_pc_nxt;
  logic        r_taken, w_taken_nxt;

  redir_req_t  w_ex, w_id, w_new, w_eff;

  pc_redir_arb #(.ISSUE_W(ISSUE_W), .CLS(RC_EX)) u_ex_arb (
    .i_valid (ex_redir_valid),
    .i_pc    (ex_redir_pc),
    .o_req   (w_ex)
  );

  pc_redir_arb #(.ISSUE_W(ISSUE_W), .CLS(RC_ID)) u_id_arb (
    .i_valid (id_redir_valid),
    .i_pc    (id_redir_pc),
    .o_req   (w_id)
  );

  // Any EX request means the D stage is on the wrong path, so ID is dropped.
  always_comb begin
    if (trap_valid)             w_new = '{cls: RC_TRAP, target: trap_pc};
    else if (w_ex.cls != RC_NONE) w_new = w_ex;
    else                        w_new = w_id;
  end

  // Equal class overwrites the latch; a lower class never displaces it.
  assign w_eff = (w_new.cls >= r_pend.cls) ? w_new : r_pend;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_pc_nxt    = r_pc;
    w_taken_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stallF) begin
          if (w_eff.cls != RC_NONE) begin
            w_state_nxt = ST_PEND;
            w_pend_nxt  = w_eff;
          end
        end else if (w_eff.cls != RC_NONE) begin
          w_pc_nxt    = w_eff.target;
          w_taken_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_pc + 32'(FETCH_BYTES);
        end
      end
      ST_PEND: begin
        // The latch is never NONE here, so w_eff always carries a target.
        if (stallF) begin
          w_pend_nxt = w_eff;
        end else begin
          w_pc_nxt    = w_eff.target;
          w_taken_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
          w_pend_nxt  = '{cls: RC_NONE, target: '0};
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pend  <= '{cls: RC_NONE, target: '0};
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_pc    <= w_pc_nxt;
      r_taken <= w_taken_nxt;
    end
  end

  assign pc               = r_pc;
  assign redirect_pending = (r_state == ST_PEND);
  assign redirect_taken   = r_taken;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stallF, trap_valid;
  logic [31:0] trap_pc;
  logic [3:0]  exv, idv;
  logic [31:0] expc [4];
  logic [31:0] idpc [4];

  logic [31:0] pc2, pc4;
  logic        pend2, pend4, tk2, tk4;

  int tests = 0;
  int fails = 0;

  // Both widths see the same stimulus; the 2-wide DUT only sees slots 0..1.
  pc_gen #(.ISSUE_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .stallF(stallF),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ex_redir_valid(exv[1:0]), .ex_redir_pc({expc[1], expc[0]}),
    .id_redir_valid(idv[1:0]), .id_redir_pc({idpc[1], idpc[0]}),
    .pc(pc2), .redirect_pending(pend2), .redirect_taken(tk2)
  );

  pc_gen #(.ISSUE_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stallF(stallF),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ex_redir_valid(exv), .ex_redir_pc({expc[3], expc[2], expc[1], expc[0]}),
    .id_redir_valid(idv), .id_redir_pc({idpc[3], idpc[2], idpc[1], idpc[0]}),
    .pc(pc4), .redirect_pending(pend4), .redirect_taken(tk4)
  );

  // Reference model, index 0 = 2-wide, 1 = 4-wide. Classes as plain ints:
  // 0 none, 1 id, 2 ex, 3 trap.
  logic [31:0] m_pc  [2];
  logic [31:0] m_ppc [2];
  int          m_pcls[2];
  bit          m_pend[2];
  bit          m_tk  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int w;
    int ncls, ecls;
    logic [31:0] npc, epc;
    w = (k == 0) ? 2 : 4;
    ncls = 0; npc = '0;
    if (trap_valid) begin
      ncls = 3; npc = trap_pc;
    end else begin
      for (int i = 0; i < w; i++)
        if (ncls == 0 && exv[i]) begin ncls = 2; npc = expc[i]; end
      for (int i = 0; i < w; i++)
        if (ncls == 0 && idv[i]) begin ncls = 1; npc = idpc[i]; end
    end
    if (ncls >= m_pcls[k]) begin ecls = ncls; epc = npc; end
    else begin ecls = m_pcls[k]; epc = m_ppc[k]; end

    if (rst) begin
      m_pc[k] = 32'hbfc0_0000; m_pcls[k] = 0; m_ppc[k] = '0;
      m_pend[k] = 1'b0; m_tk[k] = 1'b0;
    end else if (stallF) begin
      m_tk[k] = 1'b0;
      if (ecls != 0) begin m_pend[k] = 1'b1; m_pcls[k] = ecls; m_ppc[k] = epc; end
    end else begin
      if (ecls != 0) begin m_pc[k] = epc; m_tk[k] = 1'b1; end
      else begin m_pc[k] = m_pc[k] + 32'(4 * w); m_tk[k] = 1'b0; end
      m_pend[k] = 1'b0; m_pcls[k] = 0;
    end
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("w2.pc",   pc2,   m_pc[0]);
    chk("w2.pend", {31'b0, pend2}, {31'b0, m_pend[0]});
    chk("w2.tk",   {31'b0, tk2},   {31'b0, m_tk[0]});
    chk("w4.pc",   pc4,   m_pc[1]);
    chk("w4.pend", {31'b0, pend4}, {31'b0, m_pend[1]});
    chk("w4.tk",   {31'b0, tk4},   {31'b0, m_tk[1]});
  endtask

  task automatic clr();
    trap_valid = 1'b0; exv = '0; idv = '0;
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; trap_pc = '0;
    clr();
    for (int i = 0; i < 4; i++) begin expc[i] = '0; idpc[i] = '0; end
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = '0; m_ppc[k] = '0; m_pcls[k] = 0; m_pend[k] = 0; m_tk[k] = 0;
    end

    // Reset and free-run
    cyc(); cyc();
    chk("rst.pc", pc2, 32'hbfc0_0000);
    chk("rst.pend", {31'b0, pend2}, 32'd0);
    chk("rst.tk", {31'b0, tk2}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("run.pc2a", pc2, 32'hbfc0_0008);
    chk("run.pc4a", pc4, 32'hbfc0_0010);
    cyc();
    chk("run.pc2b", pc2, 32'hbfc0_0010);
    chk("run.pc4b", pc4, 32'hbfc0_0020);
    chk("run.tk", {31'b0, tk2}, 32'd0);

    // EX beats ID in the same cycle
    exv = 4'b0010; expc[1] = 32'h8000_1000;
    idv = 4'b0001; idpc[0] = 32'h8000_2000;
    cyc();
    chk("exid.pc2", pc2, 32'h8000_1000);
    chk("exid.pc4", pc4, 32'h8000_1000);
    chk("exid.tk", {31'b0, tk2}, 32'd1);
    clr();
    cyc();
    chk("exid.tk0", {31'b0, tk2}, 32'd0);
    chk("exid.seq", pc2, 32'h8000_1008);

    // Redirects during a 3-cycle stall
    stallF = 1'b1;
    idv = 4'b0001; idpc[0] = 32'h8000_3000;
    cyc();
    chk("stl.hold1", pc2, 32'h8000_1008);
    clr();
    exv = 4'b0001; expc[0] = 32'h8000_4000;
    cyc();
    chk("stl.pend2", {31'b0, pend2}, 32'd1);
    chk("stl.hold2", pc2, 32'h8000_1008);
    clr();
    cyc();
    chk("stl.pend3", {31'b0, pend2}, 32'd1);
    chk("stl.tk", {31'b0, tk2}, 32'd0);
    stallF = 1'b0;
    cyc();
    chk("stl.rel2", pc2, 32'h8000_4000);
    chk("stl.rel4", pc4, 32'h8000_4000);
    chk("stl.relpend", {31'b0, pend2}, 32'd0);

    // Pending EX is not displaced by a later ID
    stallF = 1'b1;
    exv = 4'b0001; expc[0] = 32'h8000_5000;
    cyc();
    clr();
    idv = 4'b0001; idpc[0] = 32'h8000_6000;
    cyc();
    clr();
    stallF = 1'b0;
    cyc();
    chk("pex.pc", pc2, 32'h8000_5000);

    // Trap beats EX
    trap_valid = 1'b1; trap_pc = 32'hbfc0_0380;
    exv = 4'b0001; expc[0] = 32'h8000_7000;
    cyc();
    chk("trap.pc", pc2, 32'hbfc0_0380);
    chk("trap.pend", {31'b0, pend2}, 32'd0);
    clr();
    cyc();
    chk("trap.seq", pc2, 32'hbfc0_0388);

    // Wrap-around
    exv = 4'b0001; expc[0] = 32'hffff_fff8;
    cyc();
    clr();
    cyc();
    chk("wrap.pc2", pc2, 32'h0000_0000);
    chk("wrap.pc4", pc4, 32'h0000_0008);

    // Reset while pending
    stallF = 1'b1;
    exv = 4'b0001; expc[0] = 32'h8000_8000;
    cyc();
    chk("rpend.pend", {31'b0, pend2}, 32'd1);
    clr();
    rst = 1'b1;
    cyc();
    chk("rpend.pc", pc2, 32'hbfc0_0000);
    chk("rpend.pend", {31'b0, pend2}, 32'd0);
    rst = 1'b0; stallF = 1'b0;
    cyc();
    chk("rpend.seq", pc2, 32'hbfc0_0008);

    // Upper slots: only the 4-wide DUT sees slots 2..3
    exv = 4'b1100; expc[2] = 32'h8000_9000; expc[3] = 32'h8000_a000;
    idv = 4'b0010; idpc[1] = 32'h8000_b000;
    cyc();
    chk("slot.pc4", pc4, 32'h8000_9000);
    chk("slot.pc2", pc2, 32'h8000_b000);
    clr();
    idv = 4'b0110; idpc[1] = 32'h8000_c000; idpc[2] = 32'h8000_d000;
    cyc();
    chk("slot.id4", pc4, 32'h8000_c000);
    clr();

    // Randomised traffic against the model
    for (int n = 0; n < 500; n++) begin
      stallF     = ($urandom_range(0, 9) < 4);
      trap_valid = ($urandom_range(0, 19) == 0);
      trap_pc    = $urandom;
      exv        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      idv        = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      for (int i = 0; i < 4; i++) begin expc[i] = $urandom; idpc[i] = $urandom; end
      rst        = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the N-wide issue front end. It is the successor to the fixed dual-issue next-PC register. It holds the fetch PC and resolves redirect requests each cycle from three sources: exception/trap, execute-stage branch resolution, and decode-stage jump/predicted-taken. It supports any issue width. Unlike its predecessor, it latches a redirect that arrives while fetch is stalled, so the redirect is never lost. The fetch stage consumes its outputs.

## Interface
Parameters:
- ISSUE_W, 2, number of issue slots; slot 0 is the oldest instruction.
- RESET_PC, 32'hbfc0_0000, fetch address after reset.
- FETCH_BYTES, 4*ISSUE_W, sequential PC increment per unstalled cycle.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stallF  in  1  hold the fetch PC this cycle.
- trap_valid  in  1  exception or ERET redirect from M stage.
- trap_pc  in  32  trap target.
- ex_redir_valid  in  ISSUE_W  E-stage mispredict in slot i; the target is the corrected PC, either the branch target or the fall-through.
- ex_redir_pc  in  32*ISSUE_W  slot i target in bits [32*i+31:32*i].
- id_redir_valid  in  ISSUE_W  D-stage unconditional jump or predicted-taken branch in slot i.
- id_redir_pc  in  32*ISSUE_W  slot i target.
- pc  out  32  current fetch address.
- redirect_pending  out  1  a redirect is latched and waiting for the stall to release.
- redirect_taken  out  1  pc was loaded from a redirect on the last edge.

## Operation
- Redirect classes, highest priority first: TRAP, then EX, then ID, then NONE.
- Each cycle the combinational arbiter picks the highest-priority request:
  - Within EX or ID, the lowest-index valid slot wins.
  - Any EX request suppresses every ID request, because the D stage is wrong-path.
- Pending register: pend_class and pend_pc.
  - Effective request = the arbitrated new request if its class is at least pend_class; otherwise the pending request.
  - A new request of equal class overwrites the pending one.
  - An ID request never overwrites a pending EX or TRAP request.
- State machine IDLE / PEND:
  - IDLE, stallF=1, and the effective class is not NONE: go to PEND and latch the effective request.
  - IDLE and stallF=0: pc <= effective target, or pc + FETCH_BYTES when the class is NONE.
  - PEND and stallF=1: stay in PEND; the latch is updated by the overwrite rule.
  - PEND and stallF=0: pc <= effective target and return to IDLE, clearing the latch.
- While stallF=1, pc holds its value in every state.
- redirect_pending = (state == PEND).
- Sequential increment wraps modulo 2^32.
- Target alignment is not checked. Misaligned targets load unchanged, and address-error detection is handled downstream.

## Timing
- Reset values: pc = RESET_PC, redirect_pending = 0, redirect_taken = 0, pend_class = NONE.
- A reset asserted while in PEND discards the latch.
- Redirect latency:
  - Request in cycle t with stallF=0: pc equals the target after edge t.
  - Request while stalled: pc equals the target on the first edge with stallF=0.
  - Requests need not be held across the stall.
- redirect_taken is registered. It is 1 for exactly the cycle after any edge where pc was loaded from a non-NONE class, and 0 otherwise, including during stalls.
- Simultaneous TRAP and EX/ID requests: TRAP wins, and the lower requests are dropped rather than latched.
- The block contains no combinational path from inputs to pc. redirect_pending and redirect_taken are also registered.

## Structure
- Package pc_pkg:
  - enum redir_class_e {RC_NONE, RC_ID, RC_EX, RC_TRAP}, ordered so that a numeric compare implements priority.
  - typedef redir_req_t {redir_class_e cls; logic [31:0] target;}.
  - Constant DEFAULT_RESET_PC.
- Sub-module pc_redir_arb: a parametrised ISSUE_W-slot lowest-index-first selector. It is instantiated once for EX and once for ID and returns a redir_req_t.
- pc_gen contains the merge, the pending latch, the FSM, and the pc/flag registers.

## Test plan
- Reset then free-run with ISSUE_W=2 → pc sequence bfc00000, bfc00008, bfc00010; redirect_taken=0 throughout.
- Simultaneous inputs with stallF=0: ex_redir_valid=2'b10 (slot1 pc 80001000), id_redir_valid=2'b01 (80002000), trap_valid=0 → pc=80001000 next cycle, redirect_taken=1 for one cycle.
- Redirect during a stall:
  - stallF=1 for 3 cycles.
  - Cycle 1: id redirect 80003000.
  - Cycle 2: ex redirect 80004000, with inputs deasserted afterwards.
  - Required: redirect_pending=1 from cycle 2, pc unchanged during the stall, pc=80004000 after release.
- Pending EX followed by a new ID request during the same stall → ID ignored, pc loads the EX target on release.
- Trap and EX in the same cycle with trap_pc=bfc00380 → pc=bfc00380, and no pending latch remains.
- Wrap: pc=fffffff8 with no request → next pc=00000000.
- Reset asserted mid-PEND → pc=bfc00000, redirect_pending=0.
- Repeat with ISSUE_W=4: increment is 16, and slot-priority order is honoured.
